// File: rtl/cpu_divider_ctrl.sv
// Sequencer between the execute stage and the unsigned iterative divider for DIV/DIVU/REM/REMU.
// Optional macro CPU_DIVIDER_CTRL_REUSE_EN reuses the previous quotient/remainder pair.
module cpu_divider_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic             div_start,
  output logic [31:0]      div_numerator,
  output logic [31:0]      div_denominator,
  output logic             div_sign,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  input  logic             div_done
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  // Two's-complement magnitude; 0x80000000 maps onto itself as an unsigned value.
  function automatic logic [31:0] f_abs(input logic signed [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [31:0] f_neg_if(input logic s, input logic [31:0] x);
    return s ? (~x + 32'd1) : x;
  endfunction

  state_t             r_state;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic               r_busy;
  logic               r_div_start;
  logic [31:0]        r_resp_data;
  logic [TAG_W-1:0]   r_resp_tag;
  logic [31:0]        r_num;
  logic [31:0]        r_den;
  logic               r_sign;
  logic [1:0]         r_op;

  logic               w_accept;
  logic               w_is_rem;
  logic               w_is_unsigned;
  logic               w_b_zero;
  logic [31:0]        w_num;
  logic [31:0]        w_den;
  logic               w_sign;
  logic [31:0]        w_zero_data;
  logic [31:0]        w_done_data;
  logic               w_reuse_hit;
  logic [31:0]        w_reuse_data;

  assign w_accept      = req_valid & r_req_ready;
  assign w_is_rem      = req_op[1];
  assign w_is_unsigned = req_op[0];
  assign w_b_zero      = (req_b == 32'd0);
  assign w_num         = w_is_unsigned ? req_a : f_abs(req_a);
  assign w_den         = w_is_unsigned ? req_b : f_abs(req_b);
  assign w_sign        = w_is_unsigned ? 1'b0 :
                         (w_is_rem ? req_a[31] : (req_a[31] ^ req_b[31]));
  assign w_zero_data   = w_is_rem ? req_a : 32'hFFFF_FFFF;
  assign w_done_data   = r_op[1] ? div_remainder : div_quotient;

`ifdef CPU_DIVIDER_CTRL_REUSE_EN
  // The divider hands back sign-applied results, so magnitudes are stored and
  // the requesting op's own sign is re-applied on a hit.
  logic        r_last_vld;
  logic        r_last_signed;
  logic        r_last_rem;
  logic [31:0] r_last_a;
  logic [31:0] r_last_b;
  logic [31:0] r_last_qmag;
  logic [31:0] r_last_rmag;
  logic [31:0] r_a;
  logic [31:0] r_b;

  assign w_reuse_hit  = r_last_vld & (req_a == r_last_a) & (req_b == r_last_b) &
                        (~req_op[0] == r_last_signed) & (req_op[1] != r_last_rem);
  assign w_reuse_data = f_neg_if(w_sign, req_op[1] ? r_last_rmag : r_last_qmag);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_vld    <= 1'b0;
      r_last_signed <= 1'b0;
      r_last_rem    <= 1'b0;
      r_last_a      <= '0;
      r_last_b      <= '0;
      r_last_qmag   <= '0;
      r_last_rmag   <= '0;
      r_a           <= '0;
      r_b           <= '0;
    end else begin
      if (w_accept) begin
        r_a <= req_a;
        r_b <= req_b;
      end
      if ((r_state == S_WAIT) && div_done) begin
        r_last_vld    <= 1'b1;
        r_last_signed <= ~r_op[0];
        r_last_rem    <= r_op[1];
        r_last_a      <= r_a;
        r_last_b      <= r_b;
        r_last_qmag   <= f_neg_if(r_sign, div_quotient);
        r_last_rmag   <= f_neg_if(r_sign, div_remainder);
      end
    end
  end
`else
  assign w_reuse_hit  = 1'b0;
  assign w_reuse_data = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_div_start  <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
      r_num        <= '0;
      r_den        <= '0;
      r_sign       <= 1'b0;
      r_op         <= 2'b00;
    end else begin
      case (r_state)
        // Accept: latch operands, then pick zero-divisor, reuse or divider path
        S_IDLE: begin
          if (w_accept) begin
            r_num       <= w_num;
            r_den       <= w_den;
            r_sign      <= w_sign;
            r_op        <= req_op;
            r_resp_tag  <= req_tag;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_b_zero) begin
              r_resp_data  <= w_zero_data;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (w_reuse_hit) begin
              r_resp_data  <= w_reuse_data;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_div_start <= 1'b1;
              r_state     <= S_START;
            end
          end
        end
        S_START: begin
          r_div_start <= 1'b0;
          r_state     <= S_WAIT;
        end
        // Divider running: operands stay put until done
        S_WAIT: begin
          if (div_done) begin
            r_resp_data  <= w_done_data;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready       = r_req_ready;
  assign resp_valid      = r_resp_valid;
  assign resp_data       = r_resp_data;
  assign resp_tag        = r_resp_tag;
  assign busy            = r_busy;
  assign div_start       = r_div_start;
  assign div_numerator   = r_num;
  assign div_denominator = r_den;
  assign div_sign        = r_sign;

endmodule

// File: tb/tb_cpu_divider_ctrl.sv
// Self-checking bench for cpu_divider_ctrl: directed and random requests against an
// arithmetic reference, with a behavioural iterative-divider model driving div_done.
module tb_cpu_divider_ctrl;
  localparam int TAG_W = 5;

  logic             clock;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic             div_start;
  logic [31:0]      div_numerator;
  logic [31:0]      div_denominator;
  logic             div_sign;
  logic [31:0]      m_q;
  logic [31:0]      m_r;
  logic             m_done;
  logic             spur_done;
  logic             div_done;
  int               m_cnt;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  // Reference-side memory of the last divider run, for the reuse feature
  bit          t_lvld = 1'b0;
  bit          t_ls;
  bit          t_lrem;
  logic [31:0] t_la;
  logic [31:0] t_lb;

  cpu_divider_ctrl #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy),
    .div_start(div_start), .div_numerator(div_numerator),
    .div_denominator(div_denominator), .div_sign(div_sign),
    .div_quotient(m_q), .div_remainder(m_r), .div_done(div_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Iterative divider stand-in: done asserted 32 cycles after start is sampled,
  // results negated when div_sign is set.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else begin
      m_done <= 1'b0;
      if (div_start) begin
        m_cnt <= 32;
        if (div_denominator != 32'd0) begin
          m_q <= div_sign ? 32'd0 - (div_numerator / div_denominator) : div_numerator / div_denominator;
          m_r <= div_sign ? 32'd0 - (div_numerator % div_denominator) : div_numerator % div_denominator;
        end
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_done <= 1'b1;
      end
    end
  end
  assign div_done = m_done | spur_done;

  always @(negedge clock) if (div_start === 1'b1) start_cnt++;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = op[1] ? (sa % sb) : (sa / sb);
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int hold);
    int          cyc;
    int          s0;
    int          exp_lat;
    bit          reuse;
    logic        exp_sign;
    logic [31:0] exp_d, exp_n, exp_dn, held_d;
    logic [TAG_W-1:0] held_t;
    exp_d  = ref_result(op, a, b);
`ifdef CPU_DIVIDER_CTRL_REUSE_EN
    reuse = t_lvld && (a == t_la) && (b == t_lb) && (t_ls == !op[0]) && (t_lrem != op[1]);
`else
    reuse = 1'b0;
`endif
    exp_lat  = (b == 32'd0 || reuse) ? 1 : 35;
    exp_sign = op[0] ? 1'b0 : (op[1] ? a[31] : (a[31] ^ b[31]));
    exp_n    = (op[0] || !a[31]) ? a : 32'd0 - a;
    exp_dn   = (op[0] || !b[31]) ? b : 32'd0 - b;

    @(negedge clock);
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(negedge clock); cyc++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    s0 = start_cnt;
    @(negedge clock);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_tag = TAG_W'($urandom);
    cyc = 1;
    chk("div_sign", 32'(div_sign), 32'(exp_sign));
    chk("div_numerator", div_numerator, exp_n);
    chk("div_denominator", div_denominator, exp_dn);
    while (!resp_valid && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (cyc == 20) chk("numerator_held", div_numerator, exp_n);
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("resp_data", resp_data, exp_d);
    chk("resp_tag", 32'(resp_tag), 32'(tag));
    chk("busy_in_resp", 32'(busy), 32'd1);
    chk("start_pulses", 32'(start_cnt - s0), (exp_lat == 35) ? 32'd1 : 32'd0);
    held_d = resp_data;
    held_t = resp_tag;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_data", resp_data, held_d);
      chk("hold_tag", 32'(resp_tag), 32'(held_t));
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    if (exp_lat == 35) begin
      t_lvld = 1'b1; t_la = a; t_lb = b; t_ls = !op[0]; t_lrem = op[1];
    end
  endtask

  logic [31:0] ra, rb, pa, pb;
  logic [1:0]  rop;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
    req_tag = '0; resp_ready = 1'b0; spur_done = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_numerator", div_numerator, 32'd0);
    chk("rst_denominator", div_denominator, 32'd0);
    chk("rst_div_sign", 32'(div_sign), 32'd0);
    reset = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 5'd5, 0);
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd6, 0);
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd7, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
    run_op(2'b11, 32'd5, 32'd0, 5'd10, 0);
    run_op(2'b00, 32'd5, 32'd0, 5'd11, 1);
    run_op(2'b00, 32'd12345, 32'hFFFF_FFEF, 5'd12, 10);

    // Stray done while idle must not produce a response
    @(negedge clock); spur_done = 1'b1;
    @(negedge clock); spur_done = 1'b0;
    @(negedge clock);
    chk("spur_resp_valid", 32'(resp_valid), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);

    // Reset ten cycles into WAIT
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd999; req_b = 32'd4; req_tag = 5'd3;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (11) @(negedge clock);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_div_start", 32'(div_start), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_numerator", div_numerator, 32'd0);
    chk("mid_rst_denominator", div_denominator, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    t_lvld = 1'b0;

    run_op(2'b01, 32'd1000, 32'd3, 5'd20, 0);
    run_op(2'b11, 32'd1000, 32'd3, 5'd21, 0);

    pa = 32'd1000; pb = 32'd3;
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = 32'd0; end
        2: begin
          ra = $urandom_range(0, 300);
          rb = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) ra = 32'd0 - ra;
          if ($urandom_range(0, 1) == 1) rb = 32'd0 - rb;
        end
        3: begin ra = 32'h8000_0000; rb = $urandom; end
        4: begin ra = $urandom; rb = 32'hFFFF_FFFF; end
        default: begin ra = pa; rb = pb; end
      endcase
      run_op(rop, ra, rb, TAG_W'($urandom), $urandom_range(0, 3));
      pa = ra; pb = rb;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
